// File: rtl/psum_writeback.sv
// Collects core output vectors and writes each one to a 32-bit psum SRAM as WPV consecutive words.
// Optional build macro PSUM_WB_RELU_EN clamps negative lanes to zero when a vector is captured.
module psum_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int word_bw = 32,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [addr_bw-1:0]       num_vec,
  input  logic                     in_valid,
  input  logic [psum_bw*col-1:0]   in_data,
  output logic                     in_ready,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [word_bw-1:0]       sram_din,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
);

  localparam int VEC_BW = psum_bw * col;
  localparam int WPV    = VEC_BW / word_bw;
  localparam int IDX_BW = (WPV > 1) ? $clog2(WPV) : 1;
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(WPV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [addr_bw-1:0] addr_cnt;
  logic [addr_bw-1:0] job_len;
  logic [addr_bw-1:0] vec_cnt;
  logic [addr_bw-1:0] vec_cnt_nxt;
  logic [IDX_BW-1:0]  word_idx;
  logic [IDX_BW-1:0]  nxt_idx;
  logic [VEC_BW-1:0]  vec_reg;
  logic [VEC_BW-1:0]  proc_data;
  logic [WPV-1:0][word_bw-1:0] vec_words;
  logic               last_word;

`ifdef PSUM_WB_RELU_EN
  always_comb begin
    proc_data = in_data;
    for (int i = 0; i < col; i++) begin
      if (in_data[psum_bw*i + psum_bw - 1]) proc_data[psum_bw*i +: psum_bw] = '0;
    end
  end
`else
  assign proc_data = in_data;
`endif

  assign vec_words   = vec_reg;
  assign nxt_idx     = word_idx + 1'b1;
  assign last_word   = (word_idx == LAST_IDX);
  assign vec_cnt_nxt = vec_cnt + 1'b1;

  // Handshake: a vector transfers on a rising edge where in_valid & in_ready;
  // in_ready is high only in LOAD and the producer holds in_data until then.
  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : LOAD;
      LOAD:    if (in_valid) state_nxt = WRITE;
      WRITE:   if (last_word) state_nxt = (vec_cnt_nxt == job_len) ? DONE : LOAD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // addr_cnt always points at the next word to be issued; SRAM ports are
  // loaded one cycle ahead so word k is on the port during WRITE cycle k.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_cnt  <= '0;
      job_len   <= '0;
      vec_cnt   <= '0;
      word_idx  <= '0;
      vec_reg   <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_cnt <= base_addr;
            job_len  <= num_vec;
            vec_cnt  <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            vec_reg   <= proc_data;
            word_idx  <= '0;
            sram_cen  <= 1'b0;
            sram_wen  <= 1'b0;
            sram_addr <= addr_cnt;
            sram_din  <= proc_data[word_bw-1:0];
            addr_cnt  <= addr_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (last_word) begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            vec_cnt  <= vec_cnt_nxt;
          end else begin
            word_idx  <= nxt_idx;
            sram_addr <= addr_cnt;
            sram_din  <= vec_words[nxt_idx];
            addr_cnt  <= addr_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
